us_ping_scheduler: RTL

- Time-shares the ultrasonic ranging function between the right and left sensors and produces the 20-bit echo times that feed the avoidance/turn decision logic.
- Alternates right then left: trigger pulse, echo capture, guard gap, switch sensor. Only one sensor is active at a time, so cross-talk is avoided.
- Time unit is clk cycles at 50 MHz. Downstream compares against 200000.

---
 rtl/us_ping_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/us_ping_scheduler.sv
// Alternating right/left ultrasonic ranging scheduler: trigger, echo capture, guard gap, switch sensor.
// Optional build macro US_AVG2_EN publishes the average of the previous and the new raw result per sensor.
module us_ping_scheduler #(
    parameter int TRIG_CYCLES  = 500,
    parameter int ECHO_TIMEOUT = 1000000,
    parameter int GUARD_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        echo_right,
    input  logic        echo_left,
    output logic        trig_right,
    output logic        trig_left,
    output logic [19:0] right_time,
    output logic [19:0] left_time,
    output logic        new_right,
    output logic        new_left,
    output logic        busy,
    output logic        fault
);

    localparam int CW = 22;
    localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYCLES - 1);
    localparam logic [19:0]   CLEAR_PATH   = 20'hFFFFF;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;
    typedef enum logic {SEL_RIGHT, SEL_LEFT} sel_t;

    state_t        state_q, state_d;
    sel_t          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    echoRightSync_q, echoLeftSync_q;
    logic          trigRight_q, trigLeft_q;
    logic          newRight_q, newLeft_q;
    logic          fault_q;
    logic [19:0]   rightTime_q, leftTime_q;
    logic          echoSel;
    logic          writeEn, writeClear, faultSet;
    logic [19:0]   rawVal, pubVal;

    // Two-flop synchronizers; the echo inputs are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echoRightSync_q <= 2'b00;
            echoLeftSync_q  <= 2'b00;
        end else begin
            echoRightSync_q <= {echoRightSync_q[0], echo_right};
            echoLeftSync_q  <= {echoLeftSync_q[0], echo_left};
        end
    end

    assign echoSel = (sel_q == SEL_LEFT) ? echoLeftSync_q[1] : echoRightSync_q[1];
    assign rawVal  = cnt_q[19:0];

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        writeEn    = 1'b0;
        writeClear = 1'b0;
        faultSet   = 1'b0;
        // Dropping start aborts everything without touching the result registers.
        if (!start) begin
            state_d = IDLE;
            sel_d   = SEL_RIGHT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRIG;
                    sel_d   = SEL_RIGHT;
                    cnt_d   = '0;
                end
                TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        cnt_d = '0;
                        if (echoSel) begin
                            writeEn    = 1'b1;
                            writeClear = 1'b1;
                            faultSet   = 1'b1;
                            state_d    = GUARD;
                        end else begin
                            state_d = WAIT_RISE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_RISE: begin
                    if (echoSel) begin
                        state_d = MEASURE;
                        cnt_d   = CW'(1);
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        writeEn    = 1'b1;
                        writeClear = 1'b1;
                        state_d    = GUARD;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                MEASURE: begin
                    if (echoSel) begin
                        if (cnt_q == TIMEOUT_LAST) begin
                            writeEn    = 1'b1;
                            writeClear = 1'b1;
                            state_d    = GUARD;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        writeEn = 1'b1;
                        state_d = GUARD;
                        cnt_d   = '0;
                    end
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        sel_d   = (sel_q == SEL_RIGHT) ? SEL_LEFT : SEL_RIGHT;
                        state_d = TRIG;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = SEL_RIGHT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef US_AVG2_EN
    logic [19:0] prevRight_q, prevLeft_q;
    logic [19:0] prevSel;
    logic [20:0] avgSum;

    assign prevSel = (sel_q == SEL_LEFT) ? prevLeft_q : prevRight_q;
    assign avgSum  = {1'b0, prevSel} + {1'b0, rawVal};
    assign pubVal  = writeClear ? CLEAR_PATH : avgSum[20:1];

    // Previous raw result per sensor; timeouts and faults poison it with the clear-path value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevRight_q <= CLEAR_PATH;
            prevLeft_q  <= CLEAR_PATH;
        end else if (writeEn) begin
            if (sel_q == SEL_RIGHT) begin
                prevRight_q <= writeClear ? CLEAR_PATH : rawVal;
            end else begin
                prevLeft_q <= writeClear ? CLEAR_PATH : rawVal;
            end
        end
    end
`else
    assign pubVal = writeClear ? CLEAR_PATH : rawVal;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= SEL_RIGHT;
            cnt_q       <= '0;
            trigRight_q <= 1'b0;
            trigLeft_q  <= 1'b0;
            newRight_q  <= 1'b0;
            newLeft_q   <= 1'b0;
            fault_q     <= 1'b0;
            rightTime_q <= CLEAR_PATH;
            leftTime_q  <= CLEAR_PATH;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            trigRight_q <= (state_d == TRIG) && (sel_d == SEL_RIGHT);
            trigLeft_q  <= (state_d == TRIG) && (sel_d == SEL_LEFT);
            newRight_q  <= writeEn && (sel_q == SEL_RIGHT);
            newLeft_q   <= writeEn && (sel_q == SEL_LEFT);
            if (faultSet) begin
                fault_q <= 1'b1;
            end
            if (writeEn && (sel_q == SEL_RIGHT)) begin
                rightTime_q <= pubVal;
            end
            if (writeEn && (sel_q == SEL_LEFT)) begin
                leftTime_q <= pubVal;
            end
        end
    end

    assign trig_right = trigRight_q;
    assign trig_left  = trigLeft_q;
    assign new_right  = newRight_q;
    assign new_left   = newLeft_q;
    assign right_time = rightTime_q;
    assign left_time  = leftTime_q;
    assign fault      = fault_q;
    assign busy       = (state_q != IDLE);

endmodule
